// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package riscv_fetch_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned ILEN       = 32;
  localparam int unsigned INST_BYTES = 4;
  localparam logic [ILEN-1:0] NOP    = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO of fetched {pc, instr} pairs; the head always sits in head_q.
module fetch_fifo
  import riscv_fetch_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t data_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t head_q, head_d;
  fetch_entry_t tail_q, tail_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (count_q == 2'd0) head_d = data_i;
          else                 tail_d = data_i;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new entry lands behind whatever remains.
          if (count_q == 2'd2) begin
            head_d = tail_q;
            tail_d = data_i;
          end else begin
            head_d = data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = head_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC owner and fetch front end: fetches into a 2-entry buffer, hands pairs to decode.
module instruction_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 64'd0,
  parameter logic [XLEN-1:0] IMEM_BYTES = 64'd16
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] inst_address,
  input  logic [ILEN-1:0] instruction_in,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instruction,
  output logic [XLEN-1:0] out_pc,
  output logic            done
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [1:0]      count;
  logic            pop, push, in_range;
  fetch_entry_t    wr_entry, head;

  assign in_range = pc_q < IMEM_BYTES;
  assign out_valid = count != 2'd0;
  assign pop  = out_valid & out_ready;
  assign push = ~redirect_valid & in_range & ((count != 2'd2) | pop);

  assign wr_entry.pc    = pc_q;
  assign wr_entry.instr = instruction_in;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) pc_d = redirect_pc & ~64'd3;
    else if (push)      pc_d = pc_q + XLEN'(INST_BYTES);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  fetch_fifo u_fetch_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .data_i  (wr_entry),
    .count_o (count),
    .head_o  (head)
  );

  assign inst_address    = pc_q;
  assign out_instruction = head.instr;
  assign out_pc          = head.pc;
  assign done            = ~in_range & (count == 2'd0);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit against a 4-word instruction memory.
module tb_instruction_fetch_unit;
  import riscv_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] inst_address;
  logic [31:0] instruction_in;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instruction;
  logic [63:0] out_pc;
  logic        done;

  int checks = 0;
  int failures = 0;

  logic [31:0] words [4] = '{32'h002180B3, 32'h00128233, 32'h00148493, 32'h02953423};

  always #5 clk = ~clk;

  always_comb begin
    case (inst_address)
      64'd0:   instruction_in = 32'h002180B3;
      64'd4:   instruction_in = 32'h00128233;
      64'd8:   instruction_in = 32'h00148493;
      64'd12:  instruction_in = 32'h02953423;
      default: instruction_in = NOP;
    endcase
  end

  instruction_fetch_unit #(
    .RESET_PC   (64'd0),
    .IMEM_BYTES (64'd16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .inst_address    (inst_address),
    .instruction_in  (instruction_in),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_pc          (out_pc),
    .done            (done)
  );

  task automatic apply_reset(input logic ready);
    reset = 1'b1;
    redirect_valid = 1'b0;
    out_ready = ready;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 64'd0 || out_instruction !== 32'd0) begin
      $display("FAIL reset_outputs: valid=%0b pc=%0h instr=%0h, want 0/0/0",
               out_valid, out_pc, out_instruction);
      failures++;
    end
    checks++;
    if (inst_address !== 64'd0 || done !== 1'b0) begin
      $display("FAIL reset_pc_done: addr=%0h done=%0b, want 0/0", inst_address, done);
      failures++;
    end
  endtask

  task automatic test_stream();
    apply_reset(1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 64'(4 * k) || out_instruction !== words[k]) begin
        $display("FAIL stream_%0d: valid=%0b pc=%0h instr=%0h, want 1/%0h/%0h",
                 k, out_valid, out_pc, out_instruction, 4 * k, words[k]);
        failures++;
      end
    end
    step();
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0 || inst_address !== 64'd16) begin
      $display("FAIL stream_done: done=%0b valid=%0b addr=%0h, want 1/0/10",
               done, out_valid, inst_address);
      failures++;
    end
    step();
    checks++;
    if (done !== 1'b1 || inst_address !== 64'd16) begin
      $display("FAIL stream_hold: done=%0b addr=%0h, want 1/10", done, inst_address);
      failures++;
    end
  endtask

  task automatic test_backpressure();
    apply_reset(1'b0);
    repeat (5) step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'd0 || out_instruction !== words[0]
        || inst_address !== 64'd8) begin
      $display("FAIL bp_full: valid=%0b pc=%0h instr=%0h addr=%0h, want 1/0/%0h/8",
               out_valid, out_pc, out_instruction, inst_address, words[0]);
      failures++;
    end
    out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 64'(4 * k) || out_instruction !== words[k]) begin
        $display("FAIL bp_release_%0d: valid=%0b pc=%0h instr=%0h, want 1/%0h/%0h",
                 k, out_valid, out_pc, out_instruction, 4 * k, words[k]);
        failures++;
      end
    end
  endtask

  task automatic test_redirect_full();
    apply_reset(1'b0);
    repeat (2) step();
    redirect_valid = 1'b1;
    redirect_pc = 64'h6;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || inst_address !== 64'd4) begin
      $display("FAIL redir_flush: valid=%0b addr=%0h, want 0/4", out_valid, inst_address);
      failures++;
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'd4 || out_instruction !== 32'h00128233) begin
      $display("FAIL redir_first: valid=%0b pc=%0h instr=%0h, want 1/4/00128233",
               out_valid, out_pc, out_instruction);
      failures++;
    end
  endtask

  task automatic test_redirect_pop();
    int zero_seen;
    apply_reset(1'b1);
    step();
    zero_seen = (out_valid && out_pc == 64'd0) ? 1 : 0;
    redirect_valid = 1'b1;
    redirect_pc = 64'd8;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || inst_address !== 64'd8) begin
      $display("FAIL rpop_empty: valid=%0b addr=%0h, want 0/8", out_valid, inst_address);
      failures++;
    end
    for (int k = 2; k < 4; k++) begin
      step();
      if (out_valid && out_pc == 64'd0) zero_seen++;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 64'(4 * k) || out_instruction !== words[k]) begin
        $display("FAIL rpop_after_%0d: valid=%0b pc=%0h instr=%0h, want 1/%0h/%0h",
                 k, out_valid, out_pc, out_instruction, 4 * k, words[k]);
        failures++;
      end
    end
    checks++;
    if (zero_seen !== 1) begin
      $display("FAIL rpop_once: pc0 deliveries=%0d, want 1", zero_seen);
      failures++;
    end
  endtask

  task automatic test_async_reset();
    apply_reset(1'b0);
    repeat (2) step();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 64'd0 || inst_address !== 64'd0) begin
      $display("FAIL areset_drop: valid=%0b pc=%0h addr=%0h, want 0/0/0",
               out_valid, out_pc, inst_address);
      failures++;
    end
    apply_reset(1'b1);
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'd0 || out_instruction !== words[0]) begin
      $display("FAIL areset_restart: valid=%0b pc=%0h instr=%0h, want 1/0/%0h",
               out_valid, out_pc, out_instruction, words[0]);
      failures++;
    end
  endtask

  task automatic test_done_redirect();
    apply_reset(1'b1);
    repeat (5) step();
    checks++;
    if (done !== 1'b1) begin
      $display("FAIL dr_done_first: done=%0b, want 1", done);
      failures++;
    end
    redirect_valid = 1'b1;
    redirect_pc = 64'd8;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (done !== 1'b0 || inst_address !== 64'd8) begin
      $display("FAIL dr_fall: done=%0b addr=%0h, want 0/8", done, inst_address);
      failures++;
    end
    for (int k = 2; k < 4; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 64'(4 * k) || out_instruction !== words[k]
          || done !== 1'b0) begin
        $display("FAIL dr_deliver_%0d: valid=%0b pc=%0h instr=%0h done=%0b, want 1/%0h/%0h/0",
                 k, out_valid, out_pc, out_instruction, done, 4 * k, words[k]);
        failures++;
      end
    end
    step();
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL dr_done_again: done=%0b valid=%0b, want 1/0", done, out_valid);
      failures++;
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_redirect_pop();
    test_async_reset();
    test_done_redirect();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
